// File: rtl/block_frame_sequencer.sv
// block_frame_sequencer
// Per-sample frame controller for the block fetch/decode pipeline.
//
// Each sample tick starts one frame:
//   - The pipeline is enabled for exactly one pass over the running block program.
//   - Decode-to-execute issue is gated to n_blocks_running instructions.
//   - The frame then drains until the same number of retirements arrive.
//   - Finally the fetcher is flushed back to block 0 and frame completion is reported.
// Program-length updates from the host take effect only at frame start.
module block_frame_sequencer #(
  parameter int n_blocks  = 256,
  parameter int ovr_width = 8,
  localparam int CW       = $clog2(n_blocks)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic [CW-1:0]        n_blocks_req,
  input  logic                 update_req,
  output logic                 update_ack,
  output logic [CW-1:0]        n_blocks_running,
  output logic                 pipe_enable,
  output logic                 pipe_flush,
  input  logic                 dec_out_valid,
  input  logic                 exec_ready,
  output logic                 dec_out_ready,
  output logic                 issue_fire,
  input  logic                 retire,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [ovr_width-1:0] overrun_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state_reg;
  logic [CW-1:0]        n_blocks_running_reg;
  logic [CW-1:0]        issued_cnt_reg;
  logic [CW-1:0]        retired_cnt_reg;
  logic                 update_ack_reg;
  logic                 pipe_flush_reg;
  logic                 frame_done_reg;
  logic                 overrun_reg;
  logic [ovr_width-1:0] overrun_count_reg;

  logic [CW-1:0]        eff_len;
  logic                 retire_accept;
  logic [CW-1:0]        retired_cnt_next;
  logic [CW-1:0]        issued_cnt_next;
  logic                 drain_done;

  // Length governing a frame that starts this cycle: a pending host update wins.
  assign eff_len = update_req ? n_blocks_req : n_blocks_running_reg;

  // Retires beyond the program length are a protocol error; the count saturates.
  assign retire_accept    = retire & busy & (retired_cnt_reg != n_blocks_running_reg);
  assign retired_cnt_next = retired_cnt_reg + CW'(retire_accept);
  assign issued_cnt_next  = issued_cnt_reg + CW'(1);

  // The drain finishes once all retirements are in, including one arriving this cycle.
  assign drain_done = (state_reg == DRAIN) && (retired_cnt_next == n_blocks_running_reg);

  assign busy          = (state_reg != IDLE);
  assign pipe_enable   = (state_reg == RUN);
  assign dec_out_ready = (state_reg == RUN) & exec_ready &
                         (issued_cnt_reg != n_blocks_running_reg);
  assign issue_fire    = dec_out_valid & dec_out_ready;

  assign update_ack       = update_ack_reg;
  assign n_blocks_running = n_blocks_running_reg;
  assign pipe_flush       = pipe_flush_reg;
  assign frame_done       = frame_done_reg;
  assign overrun          = overrun_reg;
  assign overrun_count    = overrun_count_reg;

  // Frame state machine, issue/retire counters and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= IDLE;
      n_blocks_running_reg <= '0;
      issued_cnt_reg       <= '0;
      retired_cnt_reg      <= '0;
      update_ack_reg       <= 1'b0;
      pipe_flush_reg       <= 1'b0;
      frame_done_reg       <= 1'b0;
    end else begin
      update_ack_reg <= 1'b0;
      pipe_flush_reg <= 1'b0;
      frame_done_reg <= 1'b0;

      if (busy) begin
        retired_cnt_reg <= retired_cnt_next;
      end

      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            if (update_req) begin
              n_blocks_running_reg <= n_blocks_req;
              update_ack_reg       <= 1'b1;
            end
            if (eff_len == '0) begin
              // An empty program completes without ever enabling the pipeline.
              frame_done_reg <= 1'b1;
            end else begin
              issued_cnt_reg  <= '0;
              retired_cnt_reg <= '0;
              state_reg       <= RUN;
            end
          end
        end

        RUN: begin
          if (issue_fire) begin
            issued_cnt_reg <= issued_cnt_next;
            if (issued_cnt_next == n_blocks_running_reg) begin
              state_reg <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (drain_done) begin
            pipe_flush_reg <= 1'b1;
            frame_done_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Overrun detection: a tick while a frame is in flight is dropped and counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg       <= 1'b0;
      overrun_count_reg <= '0;
    end else begin
      overrun_reg <= sample_tick & busy;
      if (sample_tick && busy && (overrun_count_reg != '1)) begin
        overrun_count_reg <= overrun_count_reg + ovr_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_frame_sequencer.sv
// tb_block_frame_sequencer
// Drives directed and randomized frames and checks the sequencer against a
// frame-level reference model. The model tracks the following as plain integers:
//   - running length
//   - issues
//   - retires
//   - overrun count
module tb_block_frame_sequencer;

  localparam int CW = 8;
  localparam int OW = 8;

  logic          clk;
  logic          reset;
  logic          sample_tick;
  logic [CW-1:0] n_blocks_req;
  logic          update_req;
  logic          update_ack;
  logic [CW-1:0] n_blocks_running;
  logic          pipe_enable;
  logic          pipe_flush;
  logic          dec_out_valid;
  logic          exec_ready;
  logic          dec_out_ready;
  logic          issue_fire;
  logic          retire;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic [OW-1:0] overrun_count;

  block_frame_sequencer #(.n_blocks(256), .ovr_width(OW)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_tick      (sample_tick),
    .n_blocks_req     (n_blocks_req),
    .update_req       (update_req),
    .update_ack       (update_ack),
    .n_blocks_running (n_blocks_running),
    .pipe_enable      (pipe_enable),
    .pipe_flush       (pipe_flush),
    .dec_out_valid    (dec_out_valid),
    .exec_ready       (exec_ready),
    .dec_out_ready    (dec_out_ready),
    .issue_fire       (issue_fire),
    .retire           (retire),
    .busy             (busy),
    .frame_done       (frame_done),
    .overrun          (overrun),
    .overrun_count    (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int len_model = 0;
  int ovr_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame. Modes:
  //   0 = valid/ready always high
  //   1 = ready toggling
  //   2 = random with stray ticks
  // The first 'stall' cycles hold valid low and tick every cycle.
  task automatic run_frame(input int n, input bit upd, input int mode, input int stall);
    int L;
    int issues;
    int retires;
    int cyc;
    bit rdy_phase;
    L = upd ? n : len_model;
    update_req   = upd;
    n_blocks_req = CW'(n);
    sample_tick  = 1'b1;
    step();
    sample_tick  = 1'b0;
    update_req   = 1'b0;
    n_blocks_req = CW'($urandom);
    if (upd) len_model = n;
    chk("update_ack", update_ack, upd);
    chk("n_blocks_running", n_blocks_running, len_model);
    chk("overrun_at_start", overrun, 0);
    if (L == 0) begin
      chk("empty_frame_done", frame_done, 1);
      chk("empty_busy", busy, 0);
      chk("empty_pipe_enable", pipe_enable, 0);
      chk("empty_pipe_flush", pipe_flush, 0);
      $display("frame len=%0d upd=%0d mode=%0d empty", L, upd, mode);
      return;
    end
    chk("start_frame_done", frame_done, 0);
    chk("start_busy", busy, 1);
    issues    = 0;
    retires   = 0;
    rdy_phase = 1'b1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      bit er, dv, rt, tk, exp_rdy, exp_fire;
      if (cyc < stall) begin
        dv = 1'b0;
        er = 1'($urandom % 2);
        tk = 1'b1;
      end else begin
        tk = (mode == 2) && ($urandom_range(0, 19) == 0);
        case (mode)
          0: begin er = 1'b1; dv = 1'b1; end
          1: begin er = rdy_phase; rdy_phase = !rdy_phase; dv = 1'b1; end
          default: begin er = 1'($urandom % 2); dv = 1'($urandom % 2); end
        endcase
      end
      rt = (retires < issues) && (mode == 0 || ($urandom % 2) == 1);
      exec_ready    = er;
      dec_out_valid = dv;
      retire        = rt;
      sample_tick   = tk;
      #1;
      exp_rdy  = er && (issues < L);
      exp_fire = dv && exp_rdy;
      chk("pipe_enable", pipe_enable, issues < L);
      chk("dec_out_ready", dec_out_ready, exp_rdy);
      chk("issue_fire", issue_fire, exp_fire);
      chk("busy", busy, 1);
      issues  += int'(exp_fire);
      retires += int'(rt);
      if (tk) ovr_model = (ovr_model < 255) ? ovr_model + 1 : 255;
      step();
      chk("overrun", overrun, tk);
      chk("overrun_count", overrun_count, ovr_model);
      chk("frame_done", frame_done, retires == L);
      chk("pipe_flush", pipe_flush, retires == L);
      if (retires == L) break;
    end
    exec_ready    = 1'b0;
    dec_out_valid = 1'b0;
    retire        = 1'b0;
    sample_tick   = 1'b0;
    chk("frame_completed", retires, L);
    chk("end_busy", busy, 0);
    chk("end_pipe_enable", pipe_enable, 0);
    $display("frame len=%0d upd=%0d mode=%0d issues=%0d cycles=%0d ovr=%0d",
             L, upd, mode, issues, cyc + 1, overrun_count);
  endtask

  initial begin
    reset         = 1'b1;
    sample_tick   = 1'b0;
    n_blocks_req  = '0;
    update_req    = 1'b0;
    dec_out_valid = 1'b0;
    exec_ready    = 1'b0;
    retire        = 1'b0;
    repeat (3) step();
    chk("rst_n_blocks_running", n_blocks_running, 0);
    chk("rst_pipe_enable", pipe_enable, 0);
    chk("rst_pipe_flush", pipe_flush, 0);
    chk("rst_update_ack", update_ack, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_overrun_count", overrun_count, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    $display("reset released");

    run_frame(4, 1'b1, 0, 0);
    run_frame(3, 1'b1, 1, 0);
    run_frame(5, 1'b1, 0, 1);
    run_frame(0, 1'b1, 0, 0);
    run_frame(0, 1'b0, 0, 0);
    run_frame(4, 1'b1, 0, 0);
    run_frame(4, 1'b1, 1, 0);
    run_frame(4, 1'b0, 2, 0);
    run_frame(5, 1'b1, 0, 300);
    for (int i = 0; i < 10; i++) begin
      run_frame($urandom_range(0, 20), 1'($urandom % 2), 2, 0);
    end

    // Reset in DRAIN with 2 of 4 retired.
    update_req   = 1'b1;
    n_blocks_req = 8'd4;
    sample_tick  = 1'b1;
    step();
    update_req    = 1'b0;
    sample_tick   = 1'b0;
    exec_ready    = 1'b1;
    dec_out_valid = 1'b1;
    repeat (4) step();
    exec_ready    = 1'b0;
    dec_out_valid = 1'b0;
    retire        = 1'b1;
    repeat (2) step();
    retire = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_pipe_enable", pipe_enable, 0);
    chk("drain_frame_done", frame_done, 0);
    reset  = 1'b1;
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_n_blocks_running", n_blocks_running, 0);
    chk("midrst_overrun_count", overrun_count, 0);
    chk("midrst_pipe_flush", pipe_flush, 0);
    reset = 1'b0;
    step();
    chk("postrst_frame_done", frame_done, 0);
    chk("postrst_busy", busy, 0);
    len_model = 0;
    ovr_model = 0;
    $display("reset during drain");
    run_frame(4, 1'b1, 0, 0);
    run_frame(6, 1'b0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/block_frame_sequencer.md
Name: block_frame_sequencer

Overview:
- Per-sample frame controller for the block fetch/decode pipeline.
- On each sample tick it enables the pipeline for exactly one pass over the running block program and gates decode-to-execute issue to N instructions. It then waits for N retirements, flushes the fetch pipeline and reports frame completion.
- It also owns n_blocks_running, applying host program-length updates only at frame boundaries, and detects sample overruns.

Parameters:
- n_blocks, 256, maximum blocks in program memory; count width CW = $clog2(n_blocks).
- ovr_width, 8, width of saturating overrun counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle strobe, start of a sample frame
- n_blocks_req  in  CW  host-requested program length
- update_req  in  1  level; host requests n_blocks_req be applied
- update_ack  out  1  one-cycle pulse when the update is applied
- n_blocks_running  out  CW  active program length, to fetcher
- pipe_enable  out  1  enable to fetch/buffer/decode stages
- pipe_flush  out  1  one-cycle pulse; pipeline stages treat it as reset
- dec_out_valid  in  1  decode stage out_valid
- exec_ready  in  1  execute stage ready
- dec_out_ready  out  1  gated ready returned to decode stage
- issue_fire  out  1  dec_out_valid & dec_out_ready
- retire  in  1  one-cycle pulse per completed instruction
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse at end of frame
- overrun  out  1  one-cycle pulse on a tick received while busy
- overrun_count  out  ovr_width  saturating count of overruns

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0: n_blocks_running=0, pipe_enable=0, pipe_flush=0, update_ack=0, frame_done=0, overrun=0, overrun_count=0.
  - issued_cnt and retired_cnt = 0.
- Reset mid-frame abandons the frame immediately. No frame_done is produced.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - pipe_enable=0, dec_out_ready=0.
  - On sample_tick with update_req=1: n_blocks_running <= n_blocks_req, and update_ack pulses the next cycle.
  - The new length is the one that governs this frame.
  - If the effective length is 0, frame_done pulses the next cycle and the state stays IDLE.
  - Otherwise: issued_cnt<=0, retired_cnt<=0, state<=RUN.
- RUN:
  - pipe_enable=1.
  - dec_out_ready = exec_ready & (issued_cnt != n_blocks_running). This is combinational.
  - Each issue_fire increments issued_cnt.
  - When a fire makes issued_cnt == n_blocks_running, go to DRAIN the next cycle.
  - Retire pulses are counted in RUN and in DRAIN.
- DRAIN:
  - pipe_enable=0, which freezes the prefetched fetch/decode state; dec_out_ready=0.
  - When retired_cnt == n_blocks_running (including a retire arriving this cycle), pulse pipe_flush and frame_done together on the next cycle, then go to IDLE.
  - The flush returns the fetcher to block 0 so the next frame starts there.
- update_req outside IDLE-with-tick: no effect. The host must hold it high until update_ack.
- update_req=1 with n_blocks_req equal to the current value: ack still pulses.
- sample_tick while busy:
  - The tick is ignored and the frame continues.
  - overrun pulses the next cycle.
  - overrun_count increments, saturating at all-ones.
- Retire count exceeding n_blocks_running is a protocol error. retired_cnt saturates at n_blocks_running; no other effect.
- Latency:
  - tick to pipe_enable high: 1 cycle.
  - final retire to frame_done: 1 cycle.
- busy = (state != IDLE).

Test Plan:
- Reset → all outputs 0. update_req=1, n_blocks_req=4, tick → n_blocks_running=4, update_ack 1 pulse, pipe_enable high 1 cycle after tick.
- N=4, exec_ready=1, dec_out_valid=1 continuously → exactly 4 issue_fire. dec_out_ready low after the 4th fire, pipe_enable low. 4 retire pulses → pipe_flush and frame_done pulse together 1 cycle after the 4th retire, then IDLE.
- N=3, exec_ready toggling 1/0 each cycle → 3 fires only on ready cycles. No issue while exec_ready=0. Frame completes after 3 retires.
- Tick during RUN with N=5 → overrun pulse and overrun_count=1. Frame is unaffected (5 issues). 300 overruns with ovr_width=8 → count holds at 255.
- update_req with n_blocks_req=0, tick → update_ack pulses and frame_done pulses next cycle. pipe_enable never asserts and busy stays 0.
- reset asserted in DRAIN with 2 of 4 retired → IDLE, counters 0, no frame_done. Next tick starts a clean frame.
